// File: rtl/bank_access_arbiter.sv
// Two-port front end for the 16-sub-memory bank array: round-robin read/write slots with
// aged write deferral on same-sub-memory conflicts. Optional CONFLICT_STATS_EN adds conflict_cnt.
module bank_access_arbiter #(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_DEFER = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
`ifdef CONFLICT_STATS_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  localparam logic [3:0] MaxDefer = 4'(MAX_DEFER);

  logic              rd_prio_q, rd_prio_d;
  logic              wr_prio_q, wr_prio_d;
  logic [3:0]        def_cnt_q, def_cnt_d;
  logic              rtag_v_q, rtag_q;

  logic              rd_c0, rd_c1, wr_c0, wr_c1;
  logic              rd_any, rd_both, wr_any, wr_both;
  logic              rd_win, wr_win;
  logic [ADDR_W-1:0] raddr, waddr;
  logic [DATA_W-1:0] wdata;
  logic              conflict, force_wr;
  logic              rd_gnt, wr_gnt;

  always_comb begin
    rd_c0    = req0 & ~we0;
    rd_c1    = req1 & ~we1;
    wr_c0    = req0 & we0;
    wr_c1    = req1 & we1;
    rd_any   = rd_c0 | rd_c1;
    rd_both  = rd_c0 & rd_c1;
    wr_any   = wr_c0 | wr_c1;
    wr_both  = wr_c0 & wr_c1;
    rd_win   = rd_both ? rd_prio_q : rd_c1;
    wr_win   = wr_both ? wr_prio_q : wr_c1;
    raddr    = rd_win ? addr1 : addr0;
    waddr    = wr_win ? addr1 : addr0;
    wdata    = wr_win ? wdata1 : wdata0;
    // Same sub-memory: the memory would drop the write, so only one side may go
    conflict = rd_any & wr_any & (raddr[ADDR_W-1 -: 4] == waddr[ADDR_W-1 -: 4]);
    force_wr = conflict & (def_cnt_q >= MaxDefer);
    rd_gnt   = rd_any & ~force_wr & ~rst;
    wr_gnt   = wr_any & ~(conflict & ~force_wr) & ~rst;
  end

  always_comb begin
    rd_prio_d = (rd_both & rd_gnt) ? ~rd_win : rd_prio_q;
    wr_prio_d = (wr_both & wr_gnt) ? ~wr_win : wr_prio_q;
    if (wr_gnt || !wr_any) begin
      def_cnt_d = '0;
    end else if (conflict) begin
      def_cnt_d = def_cnt_q + 4'd1;
    end else begin
      def_cnt_d = def_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_prio_q <= 1'b0;
      wr_prio_q <= 1'b0;
      def_cnt_q <= '0;
      rtag_v_q  <= 1'b0;
      rtag_q    <= 1'b0;
    end else begin
      rd_prio_q <= rd_prio_d;
      wr_prio_q <= wr_prio_d;
      def_cnt_q <= def_cnt_d;
      rtag_v_q  <= rd_gnt;
      rtag_q    <= rd_win;
    end
  end

  assign gnt0      = (rd_gnt & ~rd_win) | (wr_gnt & ~wr_win);
  assign gnt1      = (rd_gnt & rd_win) | (wr_gnt & wr_win);
  assign mem_ren   = rd_gnt;
  assign mem_raddr = rd_gnt ? raddr : '0;
  assign mem_wen   = wr_gnt;
  assign mem_waddr = wr_gnt ? waddr : '0;
  assign mem_din   = wr_gnt ? wdata : '0;

  // A reset arriving while read data is in flight drops that return
  assign rvalid0 = rtag_v_q & ~rtag_q & ~rst;
  assign rvalid1 = rtag_v_q & rtag_q & ~rst;
  assign rdata0  = rvalid0 ? mem_dout : '0;
  assign rdata1  = rvalid1 ? mem_dout : '0;

`ifdef CONFLICT_STATS_EN
  logic [15:0] conflict_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= '0;
    end else if (conflict && conflict_cnt_q != 16'hFFFF) begin
      conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_bank_access_arbiter.sv
// Self-checking bench for bank_access_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration rules.
module tb_bank_access_arbiter;

  localparam int MaxDefer = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [10:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0]  rdata0, rdata1;
  logic        mem_ren, mem_wen;
  logic [10:0] mem_raddr, mem_waddr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout = 8'h00;
`ifdef CONFLICT_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  bank_access_arbiter #(.ADDR_W(11), .DATA_W(8), .MAX_DEFER(MaxDefer)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .mem_dout(mem_dout)
`ifdef CONFLICT_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [10:0] a);
    return (a == 11'h085) ? 8'h5A : 8'(int'(a) * 7 + 3);
  endfunction

  // Memory with 1-cycle read latency; unwritten locations hold init_val
  logic [7:0] mem     [2048];
  bit         mem_w   [2048];
  always @(posedge clk) begin
    if (mem_ren) mem_dout <= mem_w[mem_raddr] ? mem[mem_raddr] : init_val(mem_raddr);
    if (mem_wen) begin
      mem[mem_waddr]   <= mem_din;
      mem_w[mem_waddr] <= 1'b1;
    end
  end

  task automatic idle();
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    req0 = 1; addr0 = 11'h085; req1 = 1; we1 = 1; addr1 = 11'h200;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_ren, mem_wen} !== 4'b0000) begin
      errors++; $display("FAIL reset_grants: got %b expected 0000", {gnt0, gnt1, mem_ren, mem_wen});
    end
    next(); rst = 0; idle();
    @(negedge clk);
    checks++;
    if ({rvalid0, rvalid1, rdata0, rdata1} !== 18'h0) begin
      errors++; $display("FAIL reset_rvalid: got %b%b %h %h expected 00 00 00",
                         rvalid0, rvalid1, rdata0, rdata1);
    end
    next();
  endtask

  task automatic test_single_read();
    req0 = 1; we0 = 0; addr0 = 11'h085;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_ren, mem_raddr} !== {3'b101, 11'h085}) begin
      errors++; $display("FAIL single_read_gnt: got %b%b%b %h expected 101 085",
                         gnt0, gnt1, mem_ren, mem_raddr);
    end
    next(); idle();
    @(negedge clk);
    checks++;
    if ({rvalid0, rdata0, rvalid1, rdata1} !== {1'b1, 8'h5A, 1'b0, 8'h00}) begin
      errors++; $display("FAIL single_read_ret: got %b %h %b %h expected 1 5a 0 00",
                         rvalid0, rdata0, rvalid1, rdata1);
    end
    next();
  endtask

  task automatic test_dual_read();
    req0 = 1; addr0 = 11'h010; req1 = 1; addr1 = 11'h020;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_raddr} !== {2'b10, 11'h010}) begin
      errors++; $display("FAIL dual_read_c1: got %b%b %h expected 10 010", gnt0, gnt1, mem_raddr);
    end
    next(); req0 = 0;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_raddr} !== {2'b01, 11'h020}) begin
      errors++; $display("FAIL dual_read_c2: got %b%b %h expected 01 020", gnt0, gnt1, mem_raddr);
    end
    checks++;
    if ({rvalid0, rvalid1, rdata0} !== {2'b10, init_val(11'h010)}) begin
      errors++; $display("FAIL dual_read_ret0: got %b%b %h expected 10 %h",
                         rvalid0, rvalid1, rdata0, init_val(11'h010));
    end
    next(); idle();
    @(negedge clk);
    checks++;
    if ({rvalid0, rvalid1, rdata1} !== {2'b01, init_val(11'h020)}) begin
      errors++; $display("FAIL dual_read_ret1: got %b%b %h expected 01 %h",
                         rvalid0, rvalid1, rdata1, init_val(11'h020));
    end
    next();
  endtask

  task automatic test_rw_parallel();
    req0 = 1; we0 = 0; addr0 = 11'h000; req1 = 1; we1 = 1; addr1 = 11'h080; wdata1 = 8'h33;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_ren, mem_wen, mem_raddr, mem_waddr, mem_din} !==
        {4'b1111, 11'h000, 11'h080, 8'h33}) begin
      errors++; $display("FAIL rw_parallel: got %b%b%b%b %h %h %h expected 1111 000 080 33",
                         gnt0, gnt1, mem_ren, mem_wen, mem_raddr, mem_waddr, mem_din);
    end
    next(); idle(); req0 = 1; addr0 = 11'h080;
    next(); idle();
    @(negedge clk);
    checks++;
    if ({rvalid0, rdata0} !== {1'b1, 8'h33}) begin
      errors++; $display("FAIL rw_readback: got %b %h expected 1 33", rvalid0, rdata0);
    end
    next();
  endtask

  task automatic test_conflict_aging();
    idle(); rst = 1; next(); rst = 0;
    req0 = 1; we0 = 0; addr0 = 11'h005; req1 = 1; we1 = 1; addr1 = 11'h07F; wdata1 = 8'hC3;
    for (int k = 1; k <= MaxDefer + 1; k++) begin
      logic wexp;
      wexp = (k == MaxDefer + 1);
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, mem_ren, mem_wen} !== {~wexp, wexp, ~wexp, wexp}) begin
        errors++; $display("FAIL aging_cycle%0d: got %b%b%b%b expected %b%b%b%b", k,
                           gnt0, gnt1, mem_ren, mem_wen, ~wexp, wexp, ~wexp, wexp);
      end
      next();
    end
    // A fresh conflicting write must be deferred again: the counter restarted
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++; $display("FAIL aging_restart: got %b%b expected 10", gnt0, gnt1);
    end
`ifdef CONFLICT_STATS_EN
    checks++;
    if (conflict_cnt !== 16'd4) begin
      errors++; $display("FAIL conflict_cnt: got %0d expected 4", conflict_cnt);
    end
`endif
    next(); idle(); next();
  endtask

  task automatic test_reset_mid_read();
    idle(); req0 = 1; addr0 = 11'h100;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++; $display("FAIL midrst_gnt: got %b expected 1", gnt0);
    end
    next(); idle(); rst = 1; req1 = 1; addr1 = 11'h200;
    @(negedge clk);
    checks++;
    if ({rvalid0, rvalid1, gnt0, gnt1, mem_ren, mem_wen} !== 6'b0) begin
      errors++; $display("FAIL midrst_outputs: got %b%b%b%b%b%b expected 000000",
                         rvalid0, rvalid1, gnt0, gnt1, mem_ren, mem_wen);
    end
    next(); rst = 0; req0 = 1; addr0 = 11'h010; req1 = 1; addr1 = 11'h020;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++; $display("FAIL midrst_prio: got %b%b expected 10", gnt0, gnt1);
    end
    next(); idle(); next();
  endtask

  // Randomized traffic on sub-memories 8..10 against a rule-level model
  logic [7:0] ref_m [2048];
  bit         ref_w [2048];

  task automatic test_random();
    bit          pend[2];
    logic        pwe[2];
    logic [10:0] pad[2];
    logic [7:0]  pwd[2];
    int rd_prio = 0, wr_prio = 0, def_cnt = 0, cstat = 0, rtag = 0;
    bit rtag_v = 0;
    logic [7:0] rexp = '0;
    for (int p = 0; p < 2; p++) pend[p] = 0;
    idle(); rst = 1; next(); rst = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int rds[$], wrs[$];
      int rwin, wwin;
      bit conf, rg, wg;
      logic [1:0] eg;
      logic [10:0] era, ewa;
      logic [7:0] ewd;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 9) < 7) begin
          pend[p] = 1;
          pwe[p]  = 1'($urandom_range(0, 1));
          pad[p]  = 11'($urandom_range(8, 10) * 128 + $urandom_range(0, 127));
          pwd[p]  = 8'($urandom);
        end
      end
      req0 = pend[0]; we0 = pwe[0]; addr0 = pad[0]; wdata0 = pwd[0];
      req1 = pend[1]; we1 = pwe[1]; addr1 = pad[1]; wdata1 = pwd[1];
      @(negedge clk);
      for (int p = 0; p < 2; p++) if (pend[p]) begin
        if (pwe[p]) wrs.push_back(p); else rds.push_back(p);
      end
      rwin = (rds.size() == 2) ? rd_prio : (rds.size() == 1 ? rds[0] : -1);
      wwin = (wrs.size() == 2) ? wr_prio : (wrs.size() == 1 ? wrs[0] : -1);
      rg = (rwin >= 0);
      wg = (wwin >= 0);
      conf = rg && wg && (pad[rwin] / 128 == pad[wwin] / 128);
      if (conf) begin
        if (def_cnt < MaxDefer) begin wg = 0; def_cnt++; end
        else begin rg = 0; def_cnt = 0; end
      end else begin
        def_cnt = 0;
      end
      eg = 2'b00;
      if (rg) eg[rwin] = 1'b1;
      if (wg) eg[wwin] = 1'b1;
      era = rg ? pad[rwin] : 11'h0;
      ewa = wg ? pad[wwin] : 11'h0;
      ewd = wg ? pwd[wwin] : 8'h0;
      checks++;
      if ({gnt0, gnt1, mem_ren, mem_wen} !== {eg[0], eg[1], rg, wg}) begin
        errors++; $display("FAIL rand_gnt cyc%0d: got %b%b%b%b expected %b%b%b%b", cyc,
                           gnt0, gnt1, mem_ren, mem_wen, eg[0], eg[1], rg, wg);
      end
      checks++;
      if ({mem_raddr, mem_waddr, mem_din} !== {era, ewa, ewd}) begin
        errors++; $display("FAIL rand_mem cyc%0d: got %h %h %h expected %h %h %h", cyc,
                           mem_raddr, mem_waddr, mem_din, era, ewa, ewd);
      end
      checks++;
      if ({rvalid0, rvalid1, rdata0, rdata1} !==
          {rtag_v && rtag == 0, rtag_v && rtag == 1,
           (rtag_v && rtag == 0) ? rexp : 8'h0, (rtag_v && rtag == 1) ? rexp : 8'h0}) begin
        errors++; $display("FAIL rand_ret cyc%0d: got %b%b %h %h expected tag_v=%0d tag=%0d %h",
                           cyc, rvalid0, rvalid1, rdata0, rdata1, rtag_v, rtag, rexp);
      end
`ifdef CONFLICT_STATS_EN
      checks++;
      if (conflict_cnt !== 16'(cstat)) begin
        errors++; $display("FAIL rand_cstat cyc%0d: got %0d expected %0d", cyc, conflict_cnt, cstat);
      end
`endif
      if (conf && cstat < 65535) cstat++;
      if (rds.size() == 2 && rg) rd_prio = 1 - rwin;
      if (wrs.size() == 2 && wg) wr_prio = 1 - wwin;
      rtag_v = rg;
      if (rg) begin
        rtag = rwin;
        rexp = ref_w[pad[rwin]] ? ref_m[pad[rwin]] : init_val(pad[rwin]);
        pend[rwin] = 0;
      end
      if (wg) begin
        ref_m[pad[wwin]] = pwd[wwin];
        ref_w[pad[wwin]] = 1'b1;
        pend[wwin] = 0;
      end
      next();
    end
    idle(); next();
  endtask

  initial begin
    idle(); rst = 1;
    test_reset();
    test_single_read();
    test_dual_read();
    test_rw_parallel();
    test_conflict_aging();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
